bounce_control: RTL

//  Rule engine for the pong ball. Sits beside the per-axis trajectory stages: it samples their ball

---
 rtl/bounce_control.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bounce_control.sv
// Pong rule engine: walls, paddle hits/misses, scoring, serve delay; drives trajectory enable/dir/speed.
// Latency: every decision is registered one edge after the edge that samples the coordinates.
// Backpressure: none; the block is a free-running controller with no handshake.
module bounce_control #(
    parameter int CWIDTH      = 9,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int PADDLE_H    = 64,
    parameter int THRESH_INIT = 500000,
    parameter int THRESH_MIN  = 100000,
    parameter int THRESH_STEP = 25000,
    parameter int SERVE_WAIT  = 25000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CWIDTH:0]   ball_x,
    input  logic [CWIDTH:0]   ball_y,
    input  logic [CWIDTH:0]   paddle_l_y,
    input  logic [CWIDTH:0]   paddle_r_y,
    output logic              active,
    output logic              dir_x,
    output logic              dir_y,
    output logic [31:0]       threshold,
    output logic              score_l,
    output logic              score_r
);

    localparam int CNT_W = (SERVE_WAIT > 0) ? $clog2(SERVE_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] SW     = CNT_W'(SERVE_WAIT);
    localparam logic [CWIDTH:0]  X_LIM  = (CWIDTH+1)'(X_MAX);
    localparam logic [CWIDTH:0]  Y_LIM  = (CWIDTH+1)'(Y_MAX);
    localparam logic [31:0]      T_INIT = 32'(THRESH_INIT);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              active_nxt, dir_x_nxt, dir_y_nxt, score_l_nxt, score_r_nxt;
    logic [31:0]       thr_nxt, thr_fast;
    logic [CWIDTH+1:0] l_end, r_end;
    logic              hit_l, hit_r;

    // Paddle span end is one bit wider so a paddle near the bottom never wraps.
    assign l_end = {1'b0, paddle_l_y} + (CWIDTH+2)'(PADDLE_H);
    assign r_end = {1'b0, paddle_r_y} + (CWIDTH+2)'(PADDLE_H);
    assign hit_l = (ball_y >= paddle_l_y) && ({1'b0, ball_y} < l_end);
    assign hit_r = (ball_y >= paddle_r_y) && ({1'b0, ball_y} < r_end);

    assign thr_fast = ({1'b0, threshold} >= (33'(THRESH_MIN) + 33'(THRESH_STEP)))
                    ? threshold - 32'(THRESH_STEP) : 32'(THRESH_MIN);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        active_nxt  = active;
        dir_x_nxt   = dir_x;
        dir_y_nxt   = dir_y;
        thr_nxt     = threshold;
        score_l_nxt = 1'b0;
        score_r_nxt = 1'b0;
        case (state)
            IDLE: begin
                active_nxt = 1'b0;
                if (start) begin
                    state_nxt = SERVE;
                    cnt_nxt   = SW;
                end
            end
            SERVE: begin
                active_nxt = 1'b0;
                if (cnt == '0) begin
                    state_nxt  = PLAY;
                    active_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PLAY: begin
                // Direction-qualified so a ball parked on a wall flips only once.
                if (dir_y && ball_y >= Y_LIM)
                    dir_y_nxt = 1'b0;
                else if (!dir_y && ball_y == '0)
                    dir_y_nxt = 1'b1;

                if (!dir_x && ball_x == '0) begin
                    if (hit_l) begin
                        dir_x_nxt = 1'b1;
                        thr_nxt   = thr_fast;
                    end else begin
                        score_r_nxt = 1'b1;
                        active_nxt  = 1'b0;
                        state_nxt   = SCORE;
                    end
                end else if (dir_x && ball_x >= X_LIM) begin
                    if (hit_r) begin
                        dir_x_nxt = 1'b0;
                        thr_nxt   = thr_fast;
                    end else begin
                        score_l_nxt = 1'b1;
                        active_nxt  = 1'b0;
                        state_nxt   = SCORE;
                    end
                end
            end
            SCORE: begin
                active_nxt = 1'b0;
                thr_nxt    = T_INIT;
                dir_x_nxt  = ~dir_x;
                cnt_nxt    = SW;
                state_nxt  = SERVE;
            end
            default: begin
                state_nxt  = IDLE;
                active_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            active    <= 1'b0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            threshold <= T_INIT;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            active    <= active_nxt;
            dir_x     <= dir_x_nxt;
            dir_y     <= dir_y_nxt;
            threshold <= thr_nxt;
            score_l   <= score_l_nxt;
            score_r   <= score_r_nxt;
        end
    end

endmodule
